// File: rtl/branch_predictor_unit_pkg.sv
// Shared types for the branch predictor: counter encodings, index-mode encodings, BTB entry layout.
package branch_predictor_unit_pkg;

    localparam int WORD_SIZE = 16;

    localparam int MODE_BIMODAL = 0;
    localparam int MODE_GSHARE  = 1;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    // Tag and counter live in separate arrays: tag width follows INDEX_BITS and
    // the counter is addressed by the (possibly hashed) prediction index.
    typedef struct packed {
        logic                 valid;
        logic                 jump;
        logic [WORD_SIZE-1:0] target;
    } btb_entry_t;

endpackage

// File: rtl/branch_predictor_unit_sat_counter2.sv
// 2-bit saturating direction counter update; purely combinational, no backpressure.
module sat_counter2
    import branch_predictor_unit_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_nxt
);

    always_comb begin
        ctr_nxt = ctr;
        if (taken) begin
            if (ctr != CTR_ST) ctr_nxt = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT) ctr_nxt = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor_unit.sv
// Direct-mapped BTB + 2-bit PHT predictor, bimodal or gshare; zero-latency lookup, one-cycle update.
// No backpressure: write_en low freezes all state while lookup keeps reflecting it.
module branch_predictor_unit
    import branch_predictor_unit_pkg::*;
#(
    parameter int WORD_SIZE  = branch_predictor_unit_pkg::WORD_SIZE,
    parameter int INDEX_BITS = 6,
    parameter int HIST_BITS  = 4,
    parameter int MODE       = MODE_BIMODAL
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  write_en,
    input  logic [WORD_SIZE-1:0]  fetch_pc,
    output logic                  pred_taken,
    output logic [WORD_SIZE-1:0]  pred_target,
    output logic [INDEX_BITS-1:0] pred_idx,
    input  logic                  upd_valid,
    input  logic [WORD_SIZE-1:0]  upd_pc,
    input  logic                  upd_is_branch,
    input  logic                  upd_taken,
    input  logic [WORD_SIZE-1:0]  upd_target,
    input  logic [INDEX_BITS-1:0] upd_idx
);

    localparam int ENTRIES  = 1 << INDEX_BITS;
    localparam int TAG_BITS = WORD_SIZE - INDEX_BITS;

    btb_entry_t           btb_q [ENTRIES];
    logic [TAG_BITS-1:0]  tag_q [ENTRIES];
    logic [1:0]           ctr_q [ENTRIES];
    logic [HIST_BITS-1:0] ghr_q;
    logic [HIST_BITS-1:0] ghr_nxt;

    logic [INDEX_BITS-1:0] pc_idx;
    logic [INDEX_BITS-1:0] ghr_ext;
    logic [INDEX_BITS-1:0] upd_pc_idx;
    logic                  hit;
    logic [1:0]            ctr_nxt;

    // BTB fields are always addressed by the raw PC; only the counter uses the hashed index.
    assign pc_idx     = fetch_pc[INDEX_BITS-1:0];
    assign upd_pc_idx = upd_pc[INDEX_BITS-1:0];
    assign ghr_ext    = INDEX_BITS'(ghr_q);
    assign pred_idx   = (MODE == MODE_GSHARE) ? (pc_idx ^ ghr_ext) : pc_idx;

    assign hit         = btb_q[pc_idx].valid && (tag_q[pc_idx] == fetch_pc[WORD_SIZE-1:INDEX_BITS]);
    assign pred_taken  = hit && (btb_q[pc_idx].jump || ctr_q[pred_idx][1]);
    assign pred_target = pred_taken ? btb_q[pc_idx].target : fetch_pc + WORD_SIZE'(1);

    assign ghr_nxt = (ghr_q << 1) | HIST_BITS'(upd_taken);

    sat_counter2 u_sat_counter2 (
        .ctr     (ctr_q[upd_idx]),
        .taken   (upd_taken),
        .ctr_nxt (ctr_nxt)
    );

    // reset_n is active-high here; the name is inherited from the older core.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_q[i] <= '{valid: 1'b0, jump: 1'b0, target: '0};
                ctr_q[i] <= CTR_WNT;
            end
            ghr_q <= '0;
        end else if (write_en && upd_valid) begin
            if (upd_is_branch) begin
                ctr_q[upd_idx] <= ctr_nxt;
                if (MODE == MODE_GSHARE) ghr_q <= ghr_nxt;
                if (upd_taken) begin
                    btb_q[upd_pc_idx] <= '{valid: 1'b1, jump: 1'b0, target: upd_target};
                    tag_q[upd_pc_idx] <= upd_pc[WORD_SIZE-1:INDEX_BITS];
                end
            end else begin
                btb_q[upd_pc_idx] <= '{valid: 1'b1, jump: 1'b1, target: upd_target};
                tag_q[upd_pc_idx] <= upd_pc[WORD_SIZE-1:INDEX_BITS];
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor_unit.sv
// Vector-table bench for the predictor: one bimodal instance, one gshare instance.
module tb_branch_predictor_unit;

    typedef struct {
        logic        rst;
        logic        we;
        logic        uv;
        logic        br;
        logic        tk;
        logic [15:0] fpc;
        logic [15:0] upc;
        logic [15:0] tgt;
        logic [5:0]  uidx;
        logic        e_tk;
        logic [15:0] e_tgt;
        logic [5:0]  e_idx;
    } vec_t;

    typedef struct {
        logic        tk;
        logic [15:0] tgt;
        logic [5:0]  idx;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // bimodal DUT signals
    logic        b_rst, b_we, b_uv, b_br, b_tk;
    logic [15:0] b_fpc, b_upc, b_tgt;
    logic [5:0]  b_uidx;
    logic        b_ptk;
    logic [15:0] b_ptgt;
    logic [5:0]  b_pidx;

    // gshare DUT signals
    logic        g_rst, g_we, g_uv, g_br, g_tk;
    logic [15:0] g_fpc, g_upc, g_tgt;
    logic [5:0]  g_uidx;
    logic        g_ptk;
    logic [15:0] g_ptgt;
    logic [5:0]  g_pidx;

    branch_predictor_unit #(.WORD_SIZE(16), .INDEX_BITS(6), .HIST_BITS(4), .MODE(0)) u_bim (
        .clk(clk), .reset_n(b_rst), .write_en(b_we), .fetch_pc(b_fpc),
        .pred_taken(b_ptk), .pred_target(b_ptgt), .pred_idx(b_pidx),
        .upd_valid(b_uv), .upd_pc(b_upc), .upd_is_branch(b_br), .upd_taken(b_tk),
        .upd_target(b_tgt), .upd_idx(b_uidx)
    );

    branch_predictor_unit #(.WORD_SIZE(16), .INDEX_BITS(6), .HIST_BITS(4), .MODE(1)) u_gsh (
        .clk(clk), .reset_n(g_rst), .write_en(g_we), .fetch_pc(g_fpc),
        .pred_taken(g_ptk), .pred_target(g_ptgt), .pred_idx(g_pidx),
        .upd_valid(g_uv), .upd_pc(g_upc), .upd_is_branch(g_br), .upd_taken(g_tk),
        .upd_target(g_tgt), .upd_idx(g_uidx)
    );

    int checks   = 0;
    int failures = 0;
    exp_t exp_q[$];
    vec_t btab[$];
    vec_t gtab[$];

    function automatic vec_t mk(logic rst, logic we, logic uv, logic br, logic tk,
                                logic [15:0] fpc, logic [15:0] upc, logic [15:0] tgt,
                                logic [5:0] uidx, logic e_tk, logic [15:0] e_tgt, logic [5:0] e_idx);
        vec_t v;
        v.rst = rst; v.we = we; v.uv = uv; v.br = br; v.tk = tk;
        v.fpc = fpc; v.upc = upc; v.tgt = tgt; v.uidx = uidx;
        v.e_tk = e_tk; v.e_tgt = e_tgt; v.e_idx = e_idx;
        return v;
    endfunction

    // Lookup-only vector: no update this cycle.
    function automatic vec_t lk(logic [15:0] fpc, logic e_tk, logic [15:0] e_tgt, logic [5:0] e_idx);
        return mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, fpc, 16'h0, 16'h0, 6'h0, e_tk, e_tgt, e_idx);
    endfunction

    task automatic check(input string name, input int n, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s vec%0d got=%h expected=%h", name, n, got, want);
        end
    endtask

    // Drive on the falling edge, sample the combinational lookup 2 units later,
    // then the following rising edge commits any update.
    task automatic apply(input vec_t v, input bit gsh, input int n);
        exp_t e;
        @(negedge clk);
        if (gsh) begin
            g_rst = v.rst; g_we = v.we; g_uv = v.uv; g_br = v.br; g_tk = v.tk;
            g_fpc = v.fpc; g_upc = v.upc; g_tgt = v.tgt; g_uidx = v.uidx;
        end else begin
            b_rst = v.rst; b_we = v.we; b_uv = v.uv; b_br = v.br; b_tk = v.tk;
            b_fpc = v.fpc; b_upc = v.upc; b_tgt = v.tgt; b_uidx = v.uidx;
        end
        exp_q.push_back('{tk: v.e_tk, tgt: v.e_tgt, idx: v.e_idx});
        #2;
        e = exp_q.pop_front();
        if (gsh) begin
            check("gsh_pred_taken",  n, {15'h0, g_ptk},  {15'h0, e.tk});
            check("gsh_pred_target", n, g_ptgt,          e.tgt);
            check("gsh_pred_idx",    n, {10'h0, g_pidx}, {10'h0, e.idx});
        end else begin
            check("bim_pred_taken",  n, {15'h0, b_ptk},  {15'h0, e.tk});
            check("bim_pred_target", n, b_ptgt,          e.tgt);
            check("bim_pred_idx",    n, {10'h0, b_pidx}, {10'h0, e.idx});
        end
    endtask

    initial begin
        b_rst = 1; b_we = 0; b_uv = 0; b_br = 0; b_tk = 0;
        b_fpc = 0; b_upc = 0; b_tgt = 0; b_uidx = 0;
        g_rst = 1; g_we = 0; g_uv = 0; g_br = 0; g_tk = 0;
        g_fpc = 0; g_upc = 0; g_tgt = 0; g_uidx = 0;

        // bimodal: rst we uv br tk fpc upc tgt uidx -> taken target idx
        btab.push_back(lk(16'h0010, 0, 16'h0011, 6'h10));                                        // 0 reset state
        btab.push_back(mk(0,1,1,1,1, 16'h0010, 16'h0010, 16'h0020, 6'h10, 0, 16'h0011, 6'h10));  // 1 same-cycle update: old value
        btab.push_back(lk(16'h0010, 1, 16'h0020, 6'h10));                                        // 2 ctr 10
        btab.push_back(lk(16'h0050, 0, 16'h0051, 6'h10));                                        // 3 tag miss
        for (int i = 0; i < 4; i++)
            btab.push_back(mk(0,1,1,1,1, 16'h0010, 16'h0010, 16'h0020, 6'h10, 1, 16'h0020, 6'h10)); // saturate at 11
        btab.push_back(mk(0,1,1,1,0, 16'h0010, 16'h0010, 16'h0020, 6'h10, 1, 16'h0020, 6'h10));  // -> 10
        btab.push_back(lk(16'h0010, 1, 16'h0020, 6'h10));
        btab.push_back(mk(0,1,1,1,0, 16'h0010, 16'h0010, 16'h0020, 6'h10, 1, 16'h0020, 6'h10));  // -> 01
        btab.push_back(lk(16'h0010, 0, 16'h0011, 6'h10));
        for (int i = 0; i < 3; i++)
            btab.push_back(mk(0,0,1,1,1, 16'h0010, 16'h0010, 16'h0030, 6'h10, 0, 16'h0011, 6'h10)); // held
        btab.push_back(mk(0,1,1,1,1, 16'h0010, 16'h0010, 16'h0030, 6'h10, 0, 16'h0011, 6'h10));  // applied once
        btab.push_back(mk(0,0,0,0,0, 16'h0010, 16'h0000, 16'h0000, 6'h00, 1, 16'h0030, 6'h10));
        btab.push_back(mk(0,1,1,1,0, 16'h0010, 16'h0010, 16'h0030, 6'h10, 1, 16'h0030, 6'h10));  // 10 -> 01 if only one inc
        btab.push_back(lk(16'h0010, 0, 16'h0011, 6'h10));
        btab.push_back(mk(0,1,1,0,1, 16'h0033, 16'h0033, 16'h0100, 6'h33, 0, 16'h0034, 6'h33));  // jump
        btab.push_back(lk(16'h0033, 1, 16'h0100, 6'h33));
        btab.push_back(lk(16'hFFFF, 0, 16'h0000, 6'h3F));                                        // wrap
        btab.push_back(mk(0,1,1,1,1, 16'h0044, 16'h0044, 16'h0200, 6'h04, 0, 16'h0045, 6'h04));
        btab.push_back(mk(0,1,1,1,0, 16'h0044, 16'h0044, 16'h0300, 6'h05, 1, 16'h0200, 6'h04));  // not-taken: no BTB write
        btab.push_back(lk(16'h0044, 1, 16'h0200, 6'h04));
        btab.push_back(mk(1,1,1,0,1, 16'h0033, 16'h0033, 16'h0100, 6'h33, 1, 16'h0100, 6'h33));  // reset mid-run
        btab.push_back(lk(16'h0033, 0, 16'h0034, 6'h33));
        btab.push_back(lk(16'h0044, 0, 16'h0045, 6'h04));
        btab.push_back(lk(16'h0010, 0, 16'h0011, 6'h10));

        // gshare, HIST_BITS=4
        gtab.push_back(lk(16'h0008, 0, 16'h0009, 6'h08));
        gtab.push_back(mk(0,1,1,1,1, 16'h0008, 16'h0001, 16'h0040, 6'h20, 0, 16'h0009, 6'h08));  // GHR 0001
        gtab.push_back(mk(0,1,1,1,0, 16'h0008, 16'h0002, 16'h0000, 6'h21, 0, 16'h0009, 6'h09));  // GHR 0010
        gtab.push_back(mk(0,1,1,1,1, 16'h0008, 16'h0003, 16'h0050, 6'h22, 0, 16'h0009, 6'h0A));  // GHR 0101
        gtab.push_back(mk(0,0,1,1,1, 16'h0008, 16'h0001, 16'h0040, 6'h20, 0, 16'h0009, 6'h0D));  // held
        gtab.push_back(lk(16'h0008, 0, 16'h0009, 6'h0D));
        gtab.push_back(mk(0,1,1,1,1, 16'h0008, 16'h0008, 16'h0123, 6'h03, 0, 16'h0009, 6'h0D));  // GHR 1011, ctr[03]=10
        gtab.push_back(lk(16'h0008, 1, 16'h0123, 6'h03));                                        // BTB at 08, ctr at 03
        gtab.push_back(mk(1,0,0,0,0, 16'h0008, 16'h0000, 16'h0000, 6'h00, 1, 16'h0123, 6'h03));
        gtab.push_back(lk(16'h0008, 0, 16'h0009, 6'h08));

        repeat (2) @(posedge clk);
        foreach (btab[i]) apply(btab[i], 1'b0, i);
        foreach (gtab[i]) apply(gtab[i], 1'b1, i);

        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d expected=0", exp_q.size());
        end
        checks++;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_predictor_unit.md
Name: branch_predictor_unit

Overview:
- Parametrised branch prediction unit for the 16-bit pipelined core; successor to the single global 2-bit counter plus BTB arrangement.
- Provides a direct-mapped BTB with a per-entry 2-bit pattern history table (PHT) and a jump flag.
- Selectable index mode: bimodal or gshare. Gshare uses a global history register (GHR).
- Lookup is combinational in IF. Update happens at branch resolution in EX, gated by the pipeline-wide cache stall enable.

Parameters:
- WORD_SIZE, 16, PC/target width.
- INDEX_BITS, 6, log2 of entry count (64 entries); tag width = WORD_SIZE-INDEX_BITS.
- HIST_BITS, 4, GHR width; must be <= INDEX_BITS; ignored when MODE=0.
- MODE, 0, 0 = bimodal (index = pc[INDEX_BITS-1:0]); 1 = gshare (index = pc[INDEX_BITS-1:0] XOR zero-extended GHR).

Ports:
- clk  in  1  clock, all state on posedge.
- reset_n  in  1  reset (the name is kept from the codebase).
- write_en  in  1  pipeline advance enable (both caches ready); low = hold all state.
- fetch_pc  in  WORD_SIZE  IF-stage PC.
- pred_taken  out  1  predict redirect.
- pred_target  out  WORD_SIZE  next PC: BTB target if pred_taken, else fetch_pc+1.
- pred_idx  out  INDEX_BITS  index used for this lookup; carried down the pipe and returned as upd_idx.
- upd_valid  in  1  EX holds a valid resolved control transfer.
- upd_pc  in  WORD_SIZE  PC of the resolved instruction.
- upd_is_branch  in  1  1 = conditional branch; 0 = unconditional jump (JMP/JAL).
- upd_taken  in  1  resolved direction (bcond & branch, or 1 for jump).
- upd_target  in  WORD_SIZE  resolved target address.
- upd_idx  in  INDEX_BITS  pred_idx captured at fetch of this instruction.

Interface facts:
- One clock; reset is synchronous and active-high. reset_n is sampled on posedge clk and is asserted when 1.
- Reset has priority over write_en.

Behaviour:
- Entry fields: valid, tag[WORD_SIZE-1:INDEX_BITS], target, jump flag, ctr[1:0].
- Reset values:
  - all valid=0, ctr=2'b01 (weakly not-taken), jump=0, GHR=0.
  - Outputs after reset: pred_taken=0, pred_target=fetch_pc+1 (wraps 16'hFFFF -> 0), pred_idx per mode.
- Lookup (combinational, zero latency):
  - hit = valid[idx] && tag[idx]==fetch_pc tag bits.
  - pred_taken = hit && (jump[idx] || ctr[idx][1]).
  - Tag lookup uses the pc index. In gshare mode the ctr is read at the hashed idx; BTB fields are always read at pc[INDEX_BITS-1:0].
- Counter FSM per entry: SNT 00, WNT 01, WT 10, ST 11.
  - Taken increments, saturating at 11; not-taken decrements, saturating at 00.
- Update (posedge, only when write_en=1 and upd_valid=1):
  - Conditional branch: ctr[upd_idx] updated by upd_taken.
  - Conditional branch, taken: BTB[upd_pc index] written with valid=1, tag, target, jump=0. An existing entry is overwritten (direct-mapped replacement).
  - Conditional branch, not-taken: BTB not written.
  - Jump: BTB written with jump=1; ctr untouched.
  - GHR (MODE=1, conditional branch only): GHR <= {GHR[HIST_BITS-2:0], upd_taken}.
- write_en=0: no state changes, even if upd_valid=1. Lookup still reflects the current state.
- Simultaneous lookup and update of the same entry: lookup returns the pre-update value; the new value is visible the next cycle.
- Reset asserted mid-operation: the full table clears on that edge regardless of upd_valid or write_en.
- Misprediction detection and PC muxing stay in the core. This block only predicts and learns.

Decomposition:
- Shared package: WORD_SIZE, counter encodings (SNT/WNT/WT/ST), MODE encodings, and the entry struct/typedef.
- One sub-module, sat_counter2 (2-bit saturating update function/module). The table arrays stay in the top level.

Test Plan:
- Reset, then fetch_pc=16'h0010 -> pred_taken=0, pred_target=16'h0011, pred_idx=6'h10.
- Update pc=16'h0010, branch, taken, target=16'h0020 (write_en=1) -> next cycle fetch 16'h0010 gives pred_taken=1 (ctr 01->10), pred_target=16'h0020. Fetch 16'h0050 (same index, different tag) gives pred_taken=0.
- Four taken updates at 16'h0010 -> ctr=11. One not-taken -> 10, still taken. A second not-taken -> 01, pred_taken=0, and the BTB entry remains valid.
- Update with upd_valid=1, write_en=0 -> no change in pred_taken/pred_target over 3 cycles. Asserting write_en then applies exactly one update.
- Jump update pc=16'h0033, target=16'h0100 -> pred_taken=1 immediately next cycle with ctr still 01. Reset asserted -> pred_taken=0 on the cycle after reset.
- MODE=1, HIST_BITS=4: branch updates taken, not-taken, taken -> GHR=4'b0101. Fetch 16'h0008 -> pred_idx=6'h0D.
